// File: rtl/stack_pkg.sv
// stack_pkg: shared command/state encodings and default sizes for the operand stack
package stack_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam int PTR_W_DEF = 4;
  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b10,
    OP_CLEAR   = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CLR  = 2'b01
  } state_e;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x DATA_W storage, one write port, combinational tos/nos reads
module stack_regfile #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  tos_addr_i,
  input  logic [PTR_W-1:0]  nos_addr_i,
  output logic [DATA_W-1:0] tos_o,
  output logic [DATA_W-1:0] nos_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  // storage is never reset; readers gate stale contents by occupancy
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign tos_o = mem_q[tos_addr_i];
  assign nos_o = mem_q[nos_addr_i];
endmodule

// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack with command handshake and DEPTH-cycle clear sweep
// Build option: define STACK_ERR_STICKY_EN to hold overflow/underflow until reset or clear completion.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              cmd_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [DATA_W-1:0] tos_o,
  output logic [DATA_W-1:0] nos_o,
  output logic [PTR_W:0]    count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  state_e state_q, state_d;
  logic [PTR_W:0] sp_q, sp_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic ovf_ev, udf_ev, clr_done, we;
  logic [PTR_W-1:0] waddr, tos_addr, nos_addr;
  logic [DATA_W-1:0] wdata, rf_tos, rf_nos;

  assign tos_addr = sp_q[PTR_W-1:0] - PTR_W'(1);
  assign nos_addr = sp_q[PTR_W-1:0] - PTR_W'(2);
  assign count_o = (state_q == ST_CLR) ? '0 : sp_q;
  assign empty_o = count_o == '0;
  assign full_o = count_o == (PTR_W+1)'(DEPTH);
  assign tos_o = empty_o ? '0 : rf_tos;
  assign nos_o = (count_o > (PTR_W+1)'(1)) ? rf_nos : '0;
  assign cmd_ready_o = state_q == ST_IDLE;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign overflow_o = ovf_q;
  assign underflow_o = udf_q;

  stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_rf (
    .clock      (clock),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .tos_addr_i (tos_addr),
    .nos_addr_i (nos_addr),
    .tos_o      (rf_tos),
    .nos_o      (rf_nos)
  );

  // command decode, clear sweep sequencing and error flag next-state
  always_comb begin
    state_d = state_q;
    sp_d = sp_q;
    idx_d = idx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    clr_done = 1'b0;
    we = 1'b0;
    waddr = sp_q[PTR_W-1:0];
    wdata = cmd_data_i;
    case (state_q)
      ST_IDLE: if (cmd_valid_i) begin
        case (cmd_op_i)
          OP_PUSH: begin
            ovf_ev = full_o;
            we = !full_o;
            sp_d = full_o ? sp_q : sp_q + (PTR_W+1)'(1);
          end
          OP_POP: begin
            rsp_valid_d = 1'b1;
            rsp_data_d = tos_o;
            udf_ev = empty_o;
            sp_d = empty_o ? sp_q : sp_q - (PTR_W+1)'(1);
          end
          OP_REPLACE: begin
            rsp_valid_d = 1'b1;
            rsp_data_d = tos_o;
            udf_ev = empty_o;
            we = !empty_o;
            waddr = tos_addr;
          end
          default: begin
            state_d = ST_CLR;
            idx_d = '0;
          end
        endcase
      end
      ST_CLR: begin
        we = 1'b1;
        waddr = idx_q;
        wdata = '0;
        idx_d = idx_q + PTR_W'(1);
        clr_done = idx_q == PTR_W'(DEPTH - 1);
        state_d = clr_done ? ST_IDLE : ST_CLR;
        sp_d = clr_done ? '0 : sp_q;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef STACK_ERR_STICKY_EN
    ovf_d = ovf_ev | (ovf_q & ~clr_done);
    udf_d = udf_ev | (udf_q & ~clr_done);
`else
    ovf_d = ovf_ev;
    udf_d = udf_ev;
`endif
  end

  // state registers with synchronous reset taking priority
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sp_q <= '0;
      idx_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q <= sp_d;
      idx_q <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Operand stack for the 16-bit stack processor. Sits directly downstream of the control unit and consumes its push/pop/replace commands and push data. Feeds popped operands to the ALU temp registers and exposes top-of-stack and next-of-stack for peeking. Single-clock LIFO with register-array storage, a command handshake and a multi-cycle clear sweep.

Parameters:
DATA_W, 16, stack word width
DEPTH, 16, number of entries (power of two, at least 2)
PTR_W, 4, log2(DEPTH)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present this cycle
cmd_op  in  2  00 PUSH, 01 POP, 10 REPLACE, 11 CLEAR
cmd_data  in  DATA_W  data for PUSH/REPLACE
cmd_ready  out  1  unit can accept a command
rsp_valid  out  1  one-cycle pulse: rsp_data holds the popped word
rsp_data  out  DATA_W  popped word
tos  out  DATA_W  current top-of-stack (0 when empty)
nos  out  DATA_W  entry below top (0 when count < 2)
count  out  PTR_W+1  occupied entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  error flag, PUSH while full
underflow  out  1  error flag, POP/REPLACE while empty

Behaviour:
- Reset (synchronous, takes priority over everything): state IDLE, sp=0, count=0, cmd_ready=1, rsp_valid=0, rsp_data=0, overflow=0, underflow=0. Storage contents are not cleared by reset, but tos/nos read 0 because of count gating.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE.
- PUSH: mem[sp]<=cmd_data, sp<=sp+1. The new tos is visible the cycle after acceptance. No rsp.
- POP: sp<=sp-1. rsp_valid=1 and rsp_data=old tos on the next cycle (1-cycle latency, registered).
- REPLACE: mem[sp-1]<=cmd_data, count unchanged. rsp_valid=1 with the old tos next cycle. Used for the ALU result write-back (pop operand, replace second operand with result).
- PUSH when full: storage, sp and count unchanged; overflow asserted. Pointer never wraps.
- POP/REPLACE when empty: no state change; underflow asserted; rsp_valid=1 with rsp_data=0.
- CLEAR: state goes IDLE->CLR. In CLR, an index counter walks 0..DEPTH-1 writing 0, one entry per cycle, with cmd_ready=0. After the last entry: sp=0, state IDLE. Total busy time is DEPTH cycles. count reads 0 from the first CLR cycle.
- FSM: IDLE (accept any op) -> CLR on CLEAR; CLR -> IDLE when the index reaches DEPTH-1. Any other encoding returns to IDLE.
- Reset mid-CLR aborts the sweep; the unit is in IDLE the next cycle.
- Commands presented while cmd_ready=0 are ignored and must be held by the producer.
- tos/nos are combinational from storage and sp.

Optional Feature:
STACK_ERR_STICKY_EN
- Defined: overflow/underflow are sticky. They stay 1 until reset or until a CLEAR command completes.
- Undefined: each flag is a one-cycle pulse in the cycle after the offending command.

Decomposition:
- Package stack_pkg holds the cmd_op encodings (OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR), the FSM state encodings (ST_IDLE, ST_CLR) and the default DATA_W/DEPTH constants.
- One natural sub-module, stack_regfile: DEPTH x DATA_W register array with a single write port and two combinational read ports (tos, nos). The FSM and pointer logic stay in stack_unit.

Test Plan:
- Reset, then PUSH 0x0005, 0x00A3 -> tos=0x00A3, nos=0x0005, count=2; POP -> next-cycle rsp_valid=1, rsp_data=0x00A3, tos=0x0005.
- Push 16 words 0..15, then a 17th PUSH 0xFFFF -> full=1, count=16, tos=15, overflow asserted (pulse, or held with STACK_ERR_STICKY_EN).
- On an empty stack, POP -> rsp_valid=1, rsp_data=0, underflow=1, count stays 0.
- PUSH 3, PUSH 4, POP, REPLACE 7 -> rsp values 4 then 3; tos=7; count=1.
- Push 3 words, CLEAR -> cmd_ready=0 for exactly 16 cycles, then count=0, tos=0. A PUSH issued during the busy window is not accepted until cmd_ready returns.
- Assert reset at CLR cycle 5 -> IDLE next cycle, cmd_ready=1, count=0; a subsequent PUSH 0x1234 gives tos=0x1234.
